mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 53 +++++
 rtl/mc_controller_aludec.sv | 25 ++
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: state enum,
// opcode/funct fields, ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type funct decoder: maps funct to an ALU operation plus a valid flag
// so the controller can trap unsupported functions.
import mc_pkg::*;

module mc_aludec (
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_valid
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    o_valid      = 1'b1;
    case (i_funct)
      FN_SLL:  o_alucontrol = ALU_SLL;
      FN_ADD:  o_alucontrol = ALU_ADD;
      FN_SUB:  o_alucontrol = ALU_SUB;
      FN_AND:  o_alucontrol = ALU_AND;
      FN_OR:   o_alucontrol = ALU_OR;
      FN_SLT:  o_alucontrol = ALU_SLT;
      default: o_valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory wait/timeout handling and a sticky
// fault state. Define MC_BNE_EN to add the bne instruction (BNEEX state).
import mc_pkg::*;

module mc_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       fault,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait;
  logic          w_mem_req, w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg;
  logic          w_regwrite, w_alusrca, w_pcwrite, w_branch, w_fault, w_pcen;
  logic [1:0]    w_alusrcb, w_pcsrc;
  logic [2:0]    w_alucontrol, w_funct_alu;
  logic          w_funct_valid, w_timeout;
`ifdef MC_BNE_EN
  logic          w_branch_ne;
`endif

  mc_aludec u_aludec (
    .i_funct      (funct),
    .o_alucontrol (w_funct_alu),
    .o_valid      (w_funct_valid)
  );

  // The wait that would bring the counter to TIMEOUT_CYCLES is the last one allowed.
  assign w_timeout = (r_wait == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)            r_wait <= '0;
      else if (w_mem_req && !mem_ready) r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_iord       = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = SRCB_RT;
    w_pcsrc      = PC_ALU;
    w_alucontrol = ALU_ADD;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_fault      = 1'b0;
`ifdef MC_BNE_EN
    w_branch_ne  = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        if (w_funct_valid) begin
          w_alucontrol = w_funct_alu;
          w_next       = S_ALUWB;
        end else begin
          w_next = S_FAULT;
        end
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = PC_ALUOUT;
        w_branch     = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = PC_ALUOUT;
        w_branch_ne  = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        w_pcsrc   = PC_JUMP;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      S_FAULT: w_fault = 1'b1;
      default: w_next  = S_FAULT;
    endcase
  end

`ifdef MC_BNE_EN
  assign w_pcen = w_pcwrite | (w_branch & zero) | (w_branch_ne & ~zero);
`else
  assign w_pcen = w_pcwrite | (w_branch & zero);
`endif

  // Side-effecting strobes are gated by reset so an access dies without a clock edge.
  assign mem_req    = w_mem_req  & ~reset;
  assign memwrite   = w_memwrite & ~reset;
  assign irwrite    = w_irwrite  & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign pcen       = w_pcen     & ~reset;
  assign iord       = w_iord;
  assign regdst     = w_regdst;
  assign memtoreg   = w_memtoreg;
  assign alusrca    = w_alusrca;
  assign alusrcb    = w_alusrcb;
  assign pcsrc      = w_pcsrc;
  assign alucontrol = w_alucontrol;
  assign fault      = w_fault;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a vector table of per-cycle inputs and
// expected Moore outputs, plus hand sequences for waits, faults and reset.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, fault;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .fault(fault), .state_o(state_o)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [16:0] obs;
  assign obs = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, pcen, fault};

  logic [16:0] E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_ADR, E_MEMRD, E_MEMWR, E_MEMWB;
  logic [16:0] E_ALUWB, E_BR_T, E_BR_N, E_ADDIWB, E_JEX, E_FAULT, E_RESET;

  function automatic logic [16:0] eo(input logic mr, io, mw, irw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu,
                                     input logic pe, flt);
    return {mr, io, mw, irw, rd, mtr, rw, asa, asb, pcs, alu, pe, flt};
  endfunction

  function automatic logic [16:0] er(input logic [2:0] alu);
    return eo(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] o_p, input logic [5:0] f, input logic z,
                      input logic r, input state_t s, input logic [16:0] e);
    vec_t v;
    v.op = o_p; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.o = e;
    tbl.push_back(v);
  endtask

  // One cycle: drive at the falling edge (also releasing reset), check 1 ns later.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    reset = 1'b0;
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.rdy;
    #1;
    chk({nm, "_state"}, 17'(state_o), 17'(v.st));
    chk({nm, "_out"}, obs, v.o);
  endtask

  task automatic step(input logic [5:0] o_p, input logic [5:0] f, input logic z,
                      input logic r, input state_t s, input logic [16:0] e,
                      input string nm);
    vec_t v;
    v.op = o_p; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.o = e;
    apply(v, nm);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk({nm, "_state"}, 17'(state_o), 17'(S_FETCH));
    chk({nm, "_out"}, obs, E_RESET);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    E_FETCH_RDY  = eo(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 1, 0);
    E_FETCH_WAIT = eo(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    E_DECODE     = eo(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0);
    E_ADR        = eo(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
    E_MEMRD      = eo(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    E_MEMWR      = eo(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    E_MEMWB      = eo(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    E_ALUWB      = eo(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    E_BR_T       = eo(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0);
    E_BR_N       = eo(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0);
    E_ADDIWB     = eo(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    E_JEX        = eo(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 1, 0);
    E_FAULT      = eo(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 1);
    E_RESET      = eo(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);

    // addi $2,$0,5: regwrite only in the fourth cycle
    push(OP_ADDI, 6'd0, 0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_ADDI, 6'd0, 0, 1, S_DECODE,  E_DECODE);
    push(OP_ADDI, 6'd0, 0, 1, S_ADDIEX,  E_ADR);
    push(OP_ADDI, 6'd0, 0, 1, S_ADDIWB,  E_ADDIWB);
    // R-type with each supported funct
    push(OP_RTYPE, FN_ADD, 0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_ADD, 0, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_ADD, 0, 1, S_RTYPEEX, er(3'b010));
    push(OP_RTYPE, FN_ADD, 0, 1, S_ALUWB,   E_ALUWB);
    push(OP_RTYPE, FN_SUB, 1, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_SUB, 1, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_SUB, 1, 1, S_RTYPEEX, er(3'b110));
    push(OP_RTYPE, FN_SUB, 1, 1, S_ALUWB,   E_ALUWB);
    push(OP_RTYPE, FN_AND, 0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_AND, 0, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_AND, 0, 1, S_RTYPEEX, er(3'b000));
    push(OP_RTYPE, FN_AND, 0, 1, S_ALUWB,   E_ALUWB);
    push(OP_RTYPE, FN_OR,  0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_OR,  0, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_OR,  0, 1, S_RTYPEEX, er(3'b001));
    push(OP_RTYPE, FN_OR,  0, 1, S_ALUWB,   E_ALUWB);
    push(OP_RTYPE, FN_SLT, 0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_SLT, 0, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_SLT, 0, 1, S_RTYPEEX, er(3'b111));
    push(OP_RTYPE, FN_SLT, 0, 1, S_ALUWB,   E_ALUWB);
    push(OP_RTYPE, FN_SLL, 0, 1, S_FETCH,   E_FETCH_RDY);
    push(OP_RTYPE, FN_SLL, 0, 1, S_DECODE,  E_DECODE);
    push(OP_RTYPE, FN_SLL, 0, 1, S_RTYPEEX, er(3'b011));
    push(OP_RTYPE, FN_SLL, 0, 1, S_ALUWB,   E_ALUWB);
    // sw (4 cycles) and lw (5 cycles) with ready tied high
    push(OP_SW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    push(OP_SW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    push(OP_SW, 6'd0, 0, 1, S_MEMADR, E_ADR);
    push(OP_SW, 6'd0, 0, 1, S_MEMWR,  E_MEMWR);
    push(OP_LW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    push(OP_LW, 6'd0, 0, 1, S_DECODE, E_DECODE);
    push(OP_LW, 6'd0, 0, 1, S_MEMADR, E_ADR);
    push(OP_LW, 6'd0, 0, 1, S_MEMRD,  E_MEMRD);
    push(OP_LW, 6'd0, 0, 1, S_MEMWB,  E_MEMWB);
    // beq taken / not taken, j
    push(OP_BEQ, 6'd0, 1, 1, S_FETCH,  E_FETCH_RDY);
    push(OP_BEQ, 6'd0, 1, 1, S_DECODE, E_DECODE);
    push(OP_BEQ, 6'd0, 1, 1, S_BEQEX,  E_BR_T);
    push(OP_BEQ, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    push(OP_BEQ, 6'd0, 0, 1, S_DECODE, E_DECODE);
    push(OP_BEQ, 6'd0, 0, 1, S_BEQEX,  E_BR_N);
    push(OP_J,   6'd0, 0, 1, S_FETCH,  E_FETCH_RDY);
    push(OP_J,   6'd0, 0, 1, S_DECODE, E_DECODE);
    push(OP_J,   6'd0, 0, 1, S_JEX,    E_JEX);

    do_reset("rst0");
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Three fetch waits then ready on the last allowed cycle; lw with 3-cycle memory delay
    for (int i = 0; i < 3; i++) step(OP_LW, 6'd0, 0, 0, S_FETCH, E_FETCH_WAIT, "fwait");
    step(OP_LW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "fwait_done");
    step(OP_LW, 6'd0, 0, 1, S_DECODE, E_DECODE,    "lwd_dec");
    step(OP_LW, 6'd0, 0, 0, S_MEMADR, E_ADR,       "lwd_adr");
    for (int i = 0; i < 3; i++) step(OP_LW, 6'd0, 0, 0, S_MEMRD, E_MEMRD, "lwd_wait");
    step(OP_LW, 6'd0, 0, 1, S_MEMRD, E_MEMRD, "lwd_rdy");
    step(OP_LW, 6'd0, 0, 0, S_MEMWB, E_MEMWB, "lwd_wb");

    // Illegal opcode traps in DECODE; fault is absorbing
    step(6'b111111, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "badop_f");
    step(6'b111111, 6'd0, 0, 1, S_DECODE, E_DECODE,    "badop_d");
    step(6'b111111, 6'd0, 0, 1, S_FAULT,  E_FAULT,     "badop_flt");
    step(OP_J,      6'd0, 1, 1, S_FAULT,  E_FAULT,     "badop_stick1");
    step(OP_LW,     6'd0, 0, 0, S_FAULT,  E_FAULT,     "badop_stick2");
    do_reset("rst1");

    // Four fetch waits exhaust the budget
    for (int i = 0; i < 4; i++) step(OP_LW, 6'd0, 0, 0, S_FETCH, E_FETCH_WAIT, "to_wait");
    step(OP_LW, 6'd0, 0, 0, S_FAULT, E_FAULT, "to_flt");
    step(OP_LW, 6'd0, 0, 1, S_FAULT, E_FAULT, "to_stick1");
    step(OP_LW, 6'd0, 0, 1, S_FAULT, E_FAULT, "to_stick2");
    do_reset("rst2");

    // Unknown funct traps in RTYPEEX without a register write
    step(OP_RTYPE, 6'b000111, 0, 1, S_FETCH,   E_FETCH_RDY, "badfn_f");
    step(OP_RTYPE, 6'b000111, 0, 1, S_DECODE,  E_DECODE,    "badfn_d");
    step(OP_RTYPE, 6'b000111, 0, 1, S_RTYPEEX, er(3'b010),  "badfn_ex");
    step(OP_RTYPE, 6'b000111, 0, 1, S_FAULT,   E_FAULT,     "badfn_flt");
    do_reset("rst3");

    // bne: branch on not-zero when enabled, illegal otherwise
    step(OP_BNE, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "bne_f");
    step(OP_BNE, 6'd0, 0, 1, S_DECODE, E_DECODE,    "bne_d");
`ifdef MC_BNE_EN
    step(OP_BNE, 6'd0, 0, 1, S_BNEEX,  E_BR_T,      "bne_taken");
    step(OP_BNE, 6'd0, 1, 1, S_FETCH,  E_FETCH_RDY, "bne_f2");
    step(OP_BNE, 6'd0, 1, 1, S_DECODE, E_DECODE,    "bne_d2");
    step(OP_BNE, 6'd0, 1, 1, S_BNEEX,  E_BR_N,      "bne_not");
`else
    step(OP_BNE, 6'd0, 0, 1, S_FAULT,  E_FAULT,     "bne_flt");
`endif
    do_reset("rst4");

    // Asynchronous reset in the middle of a store wait
    step(OP_SW, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "arst_f");
    step(OP_SW, 6'd0, 0, 1, S_DECODE, E_DECODE,    "arst_d");
    step(OP_SW, 6'd0, 0, 0, S_MEMADR, E_ADR,       "arst_adr");
    step(OP_SW, 6'd0, 0, 0, S_MEMWR,  E_MEMWR,     "arst_wr");
    #2;
    reset = 1'b1;
    #1;
    chk("arst_memreq",   17'(mem_req),  17'd0);
    chk("arst_memwrite", 17'(memwrite), 17'd0);
    chk("arst_state",    17'(state_o),  17'(S_FETCH));
    step(OP_ADDI, 6'd0, 0, 1, S_FETCH,  E_FETCH_RDY, "arst_refetch");
    step(OP_ADDI, 6'd0, 0, 1, S_DECODE, E_DECODE,    "arst_redecode");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
